// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared FSM state type and load funct3 encodings for the write-back stage
package wb_stage_pkg;
    typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: aligns a raw data-memory word and sign/zero-extends it by load type
// funct3  : load type (LB/LH/LW/LBU/LHU; anything else passes the word)
// addr_lo : byte address bits [1:0]
// rdata   : raw word from data memory
// ext     : aligned, extended result
module load_extend
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b   = rdata[{addr_lo, 3'b000} +: 8];
        h   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
              funct3 == F3_LBU ? {24'b0, b}       :
              funct3 == F3_LH  ? {{16{h[15]}}, h} :
              funct3 == F3_LHU ? {16'b0, h}       : rdata;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32I write-back stage; waits for load data, extends it, drives the regfile write port
// in_*        : retiring instruction from MEM, handshake in_valid/in_ready
// mem_rvalid  : single-cycle load-data strobe with mem_rdata
// reg_write/w_adrs/w_data : registered regfile write port, zeroed when not writing
// retire      : one-cycle pulse per retired instruction
// instret     : 64-bit retired count, present only when WB_INSTRET_EN is defined
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_wb_data,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            reg_write,
    output logic [4:0]      w_adrs,
    output logic [XLEN-1:0] w_data,
    output logic            retire
`ifdef WB_INSTRET_EN
    ,output logic [63:0]    instret
`endif
);
    wb_state_e       state, state_n;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [XLEN-1:0] ext;
    logic            fire_alu, fire_ld, wr;
    logic [4:0]      adrs_n;
    logic [XLEN-1:0] data_n;

    load_extend #(.XLEN(XLEN)) u_ext (
        .funct3 (f3_q),
        .addr_lo(lo_q),
        .rdata  (mem_rdata),
        .ext    (ext)
    );

    always_comb begin
        in_ready = state == IDLE;
        fire_alu = in_ready && in_valid && !in_is_load;
        fire_ld  = state == WAIT_LOAD && mem_rvalid;
        state_n  = in_ready && in_valid && in_is_load ? WAIT_LOAD :
                   fire_ld ? IDLE : state;
        wr       = fire_alu ? in_reg_write && in_rd != 5'd0 : fire_ld && rw_q && rd_q != 5'd0;
        adrs_n   = !wr ? 5'd0 : fire_alu ? in_rd : rd_q;
        data_n   = !wr ? '0 : fire_alu ? in_wb_data : ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            reg_write <= 1'b0;
            w_adrs    <= 5'd0;
            w_data    <= '0;
            retire    <= 1'b0;
        end else begin
            state     <= state_n;
            reg_write <= wr;
            w_adrs    <= adrs_n;
            w_data    <= data_n;
            retire    <= fire_alu || fire_ld;
        end
    end

    // Load context is only meaningful in WAIT_LOAD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid && in_is_load) begin
            rd_q <= in_rd;
            rw_q <= in_reg_write;
            f3_q <= in_funct3;
            lo_q <= in_addr_lo;
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)
            instret <= 64'd0;
        else if (retire)
            instret <= instret + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage with cycle-exact write checks
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [31:0] in_wb_data = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        reg_write;
    logic [4:0]  w_adrs;
    logic [31:0] w_data;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    typedef struct {
        int          cyc;
        logic        rw;
        logic [4:0]  adrs;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    localparam logic [31:0] RD = 32'h80F0_7F81;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_reg_write(in_reg_write),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .in_wb_data  (in_wb_data),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .reg_write   (reg_write),
        .w_adrs      (w_adrs),
        .w_data      (w_data),
        .retire      (retire)
`ifdef WB_INSTRET_EN
        ,.instret    (instret)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cycle: either the front scoreboard entry is due now, or outputs must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() != 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("retire", retire, 1);
                chk("reg_write", reg_write, e.rw);
                chk("w_adrs", w_adrs, e.adrs);
                chk("w_data", w_data, e.data);
            end else begin
                chk("idle_retire", retire, 0);
                chk("idle_reg_write", reg_write, 0);
                chk("idle_w_adrs", w_adrs, 0);
                chk("idle_w_data", w_data, 0);
            end
        end
    end

    task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.rw   = rw && rd != 5'd0;
        e.adrs = e.rw ? rd : 5'd0;
        e.data = e.rw ? d : 32'd0;
        q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] rd, input logic rw, input logic [31:0] d);
        chk("alu_ready", in_ready, 1);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_reg_write = rw; in_wb_data = d;
        push(rw, rd, d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                        input logic [1:0] lo, input int dly, input logic [31:0] exp_d);
        chk("ld_ready", in_ready, 1);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_reg_write = rw;
        in_funct3 = f3; in_addr_lo = lo; in_wb_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("ld_stall_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("ld_wait_ready", in_ready, 0);
        mem_rvalid = 1'b1; mem_rdata = RD;
        push(rw, rd, exp_d);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        chk("ld_done_ready", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_retire", retire, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_w_data", w_data, 0);
`ifdef WB_INSTRET_EN
        chk("rst_instret", instret, 0);
`endif
        alu(5'd5, 1'b1, 32'h1234_5678);
        alu(5'd0, 1'b1, 32'hFFFF_FFFF);
        alu(5'd9, 1'b0, 32'hCAFE_F00D);
        alu(5'd31, 1'b1, 32'h0000_0001);
        load(5'd7, 1'b1, 3'b000, 2'd0, 0, 32'hFFFF_FF81);
        load(5'd7, 1'b1, 3'b100, 2'd3, 0, 32'h0000_0080);
        load(5'd7, 1'b1, 3'b001, 2'd2, 0, 32'hFFFF_80F0);
        load(5'd7, 1'b1, 3'b101, 2'd0, 0, 32'h0000_7F81);
        load(5'd7, 1'b1, 3'b010, 2'd1, 0, 32'h80F0_7F81);
        load(5'd7, 1'b1, 3'b000, 2'd1, 0, 32'h0000_007F);
        load(5'd7, 1'b1, 3'b000, 2'd2, 0, 32'hFFFF_FFF0);
        load(5'd7, 1'b1, 3'b101, 2'd2, 0, 32'h0000_80F0);
        load(5'd7, 1'b1, 3'b011, 2'd3, 0, 32'h80F0_7F81);
        load(5'd0, 1'b1, 3'b010, 2'd0, 0, 32'h80F0_7F81);
        load(5'd8, 1'b0, 3'b010, 2'd0, 0, 32'h80F0_7F81);
        load(5'd12, 1'b1, 3'b001, 2'd0, 4, 32'h0000_7F81);
        alu(5'd13, 1'b1, 32'hA5A5_0F0F);
        alu(5'd14, 1'b1, 32'h0F0F_A5A5);
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = RD;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("stray_rvalid_ready", in_ready, 1);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd3; in_reg_write = 1'b1; in_funct3 = 3'b010;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        chk("midload_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midload_rst_ready", in_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = RD;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("late_rvalid_ready", in_ready, 1);
        chk("late_rvalid_retire", retire, 0);
        chk("late_rvalid_reg_write", reg_write, 0);
        chk("late_rvalid_w_adrs", w_adrs, 0);
        chk("late_rvalid_w_data", w_data, 0);
`ifdef WB_INSTRET_EN
        chk("midload_instret", instret, 0);
        alu(5'd1, 1'b1, 32'd11);
        alu(5'd0, 1'b1, 32'd22);
        alu(5'd2, 1'b1, 32'd33);
        load(5'd4, 1'b1, 3'b010, 2'd0, 1, 32'h80F0_7F81);
        @(posedge clk); #1;
        chk("instret_count", instret, 64'd4);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret;
        chk("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        alu(5'd6, 1'b1, 32'd44);
        @(posedge clk); #1;
        chk("instret_wrap", instret, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
